// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared constants and types for the 3x3 matrix-multiply stream controller.
//   MAT_N / MAT_ELEMS : matrix dimension and element count
//   OP_W / RES_W      : operand and product element widths
//   IN_BYTES          : operand bytes per job (A then B)
//   OUT_BYTES         : result bytes per job (3 bytes per C element)
//   state_t           : controller FSM states
// -----------------------------------------------------------------------------
package matmul_pkg;

  localparam int MAT_N     = 3;
  localparam int MAT_ELEMS = 9;
  localparam int OP_W      = 8;
  localparam int RES_W     = 18;
  localparam int IN_BYTES  = 18;
  localparam int OUT_BYTES = 27;

  // Index widths: element index must also reach MAT_ELEMS (checksum slot).
  localparam int ELEM_W    = 4;
  localparam int IN_CNT_W  = 5;

  typedef logic [ELEM_W-1:0]   elem_idx_t;
  typedef logic [IN_CNT_W-1:0] in_cnt_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

endpackage

// File: rtl/mat_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// mat_stream_ctrl_if
// Byte-stream handshakes of the matrix controller.
//   in_valid/in_data/in_ready    : operand byte stream into the controller
//   out_valid/out_data/out_ready : result byte stream out of the controller
// Modports: slave = controller view, master = producer/consumer view.
// -----------------------------------------------------------------------------
interface mat_stream_ctrl_if;
  import matmul_pkg::*;

  logic            in_valid;
  logic [OP_W-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [OP_W-1:0] out_data;
  logic            out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/mat_result_ser.sv
// -----------------------------------------------------------------------------
// mat_result_ser
// Captures the nine 18-bit products and serializes them little-endian,
// three bytes per element, C[0] first. Optional trailing XOR checksum byte
// when MAT_STREAM_CHECKSUM_EN is defined.
// Ports:
//   clk, reset   : clock, async active-high reset
//   capture      : load mm_C into the result registers, clear byte index
//   send_active  : controller is in SEND; drives out_valid
//   mm_C         : product matrix, row-major
//   out_ready    : downstream accepts the current byte
//   out_valid    : result byte valid
//   out_data     : result byte (0 when not sending)
//   last_hs      : final byte of the job is being accepted this cycle
// -----------------------------------------------------------------------------
module mat_result_ser
  import matmul_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             send_active,
  input  logic [RES_W-1:0] mm_C [MAT_ELEMS],
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OP_W-1:0]  out_data,
  output logic             last_hs
);

  logic [RES_W-1:0] res_q [MAT_ELEMS];
  elem_idx_t        elem_q;
  logic [1:0]       sub_q;
  logic [RES_W-1:0] cur;
  logic             hs;
  logic             last_byte;
`ifdef MAT_STREAM_CHECKSUM_EN
  logic [OP_W-1:0]  chk_q;
`endif

  assign out_valid = send_active;
  assign hs        = send_active & out_ready;

`ifdef MAT_STREAM_CHECKSUM_EN
  assign last_byte = (elem_q == ELEM_W'(MAT_ELEMS));
`else
  assign last_byte = (elem_q == ELEM_W'(MAT_ELEMS - 1)) && (sub_q == 2'd2);
`endif
  assign last_hs = hs & last_byte;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur      = '0;
    out_data = '0;
    if (elem_q < ELEM_W'(MAT_ELEMS)) cur = res_q[elem_q];
    if (send_active) begin
      case (sub_q)
        2'd0:    out_data = cur[OP_W-1:0];
        2'd1:    out_data = cur[2*OP_W-1:OP_W];
        default: out_data = {{(3*OP_W-RES_W){1'b0}}, cur[RES_W-1:2*OP_W]};
      endcase
`ifdef MAT_STREAM_CHECKSUM_EN
      if (elem_q == ELEM_W'(MAT_ELEMS)) out_data = chk_q;
`endif
    end
  end

  // NOTE: the result registers are reset because out_data must read 0 and no stale
  // product may leak after an abort; plain storage arrays elsewhere need not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAT_ELEMS; i++) res_q[i] <= '0;
      elem_q <= '0;
      sub_q  <= '0;
`ifdef MAT_STREAM_CHECKSUM_EN
      chk_q  <= '0;
`endif
    end else if (capture) begin
      for (int i = 0; i < MAT_ELEMS; i++) res_q[i] <= mm_C[i];
      elem_q <= '0;
      sub_q  <= '0;
`ifdef MAT_STREAM_CHECKSUM_EN
      chk_q  <= '0;
`endif
    end else if (hs) begin
      if (sub_q == 2'd2) begin
        sub_q  <= '0;
        elem_q <= elem_q + ELEM_W'(1);
      end else begin
        sub_q  <= sub_q + 2'd1;
      end
`ifdef MAT_STREAM_CHECKSUM_EN
      chk_q <= chk_q ^ out_data;
`endif
    end
  end

endmodule

// File: rtl/mat_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mat_stream_ctrl
// Loads two 3x3 byte matrices from a byte stream, runs an external
// matrix_mult block, captures its 18-bit products and streams them back.
// Optional feature macro: MAT_STREAM_CHECKSUM_EN (adds XOR checksum byte).
// Ports:
//   clk, reset : clock, async active-high reset
//   s          : operand/result byte streams (slave modport)
//   mm_A, mm_B : row-major operand matrices to matrix_mult
//   mm_enable  : start/hold request to matrix_mult
//   mm_C       : row-major product from matrix_mult
//   mm_done    : product valid
//   busy       : high in every state except LOAD
//   err        : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mat_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  mat_stream_ctrl_if.slave s,
  output logic [OP_W-1:0]  mm_A [MAT_ELEMS],
  output logic [OP_W-1:0]  mm_B [MAT_ELEMS],
  output logic             mm_enable,
  input  logic [RES_W-1:0] mm_C [MAT_ELEMS],
  input  logic             mm_done,
  output logic             busy,
  output logic             err
);

  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t           state, state_next;
  in_cnt_t          byte_cnt_q;
  logic [CYC_W-1:0] cyc_cnt_q;
  logic             load_hs;
  logic             timeout;
  logic             capture;
  logic             send_active;
  logic             ser_last_hs;
  logic             in_ready;

  assign s.in_ready = in_ready;

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values; blocking assignment belongs only in combinational blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    mm_enable   = 1'b0;
    load_hs     = 1'b0;
    timeout     = 1'b0;
    capture     = 1'b0;
    send_active = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        load_hs  = s.in_valid;
        if (s.in_valid && byte_cnt_q == in_cnt_t'(IN_BYTES - 1)) state_next = COMPUTE;
      end
      COMPUTE: begin
        mm_enable = 1'b1;
        // mm_done wins over a timeout landing in the same cycle.
        if (mm_done) begin
          state_next = CAPTURE;
        end else if (cyc_cnt_q == CYC_W'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = LOAD;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        send_active = 1'b1;
        if (ser_last_hs) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Operand loader, COMPUTE cycle counter and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAT_ELEMS; i++) begin
        mm_A[i] <= '0;
        mm_B[i] <= '0;
      end
      byte_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      err        <= 1'b0;
    end else begin
      if (load_hs) begin
        if (byte_cnt_q < in_cnt_t'(MAT_ELEMS))
          mm_A[byte_cnt_q[ELEM_W-1:0]] <= s.in_data;
        else
          mm_B[ELEM_W'(byte_cnt_q - in_cnt_t'(MAT_ELEMS))] <= s.in_data;
        byte_cnt_q <= (byte_cnt_q == in_cnt_t'(IN_BYTES - 1)) ? '0 : byte_cnt_q + in_cnt_t'(1);
      end
      cyc_cnt_q <= (state == COMPUTE) ? cyc_cnt_q + CYC_W'(1) : '0;
      if (timeout) err <= 1'b1;
    end
  end

  mat_result_ser u_ser (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .send_active (send_active),
    .mm_C        (mm_C),
    .out_ready   (s.out_ready),
    .out_valid   (s.out_valid),
    .out_data    (s.out_data),
    .last_hs     (ser_last_hs)
  );

endmodule
